// File: rtl/gpio_clkgen_pkg.sv
// Shared constants and types for the gpio_clkgen output port / clock generator.
package gpio_clkgen_pkg;
    localparam int ADDR_W  = 3;
    localparam int BURST_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_DIVISOR  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_BURST    = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd7;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_RESTART = 1;
    localparam int STAT_RUNNING = 0;
    localparam int STAT_DONE    = 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} gen_state_e;
endpackage

// File: rtl/gpio_clkgen_if.sv
// Avalon-MM slave bus bundle for gpio_clkgen (zero wait state, write-only strobe).
interface gpio_clkgen_if;
    import gpio_clkgen_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gpio_clkgen_divider.sv
// Shared clock generator: divider counter, generated clock and optional burst counter.
// Burst limiting is built only when GPIO_CLKGEN_BURST_EN is defined.
module gpio_clkgen_divider
    import gpio_clkgen_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_set,
    input  logic               run_clr,
    input  logic               restart,
    input  logic [DIV_W-1:0]   divisor,
    input  logic [BURST_W-1:0] burst,
    output logic               gclk,
    output logic               running,
    output logic               done_pulse
);
    gen_state_e       state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic             gclk_nxt;
    logic             tick, fall, expire;

    assign tick    = (cnt >= divisor);
    assign fall    = tick && gclk;
    assign running = (state == RUN);

`ifdef GPIO_CLKGEN_BURST_EN
    logic [BURST_W-1:0] bcnt, bcnt_nxt;

    // Expiry is decided on the falling toggle that completes the last period.
    assign expire = fall && (burst != '0) && ((bcnt + BURST_W'(1)) == burst);

    always_comb begin
        bcnt_nxt = bcnt;
        if (state == IDLE || run_clr || restart || expire)
            bcnt_nxt = '0;
        else if (fall)
            bcnt_nxt = bcnt + BURST_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bcnt <= '0;
        else          bcnt <= bcnt_nxt;
    end
`else
    logic unused_burst;
    assign unused_burst = ^burst;
    assign expire       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            gclk  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gclk  <= gclk_nxt;
        end
    end

    // Priority while running: stop > restart (incl. RUN rewrite at expiry) > expiry > count.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        gclk_nxt   = gclk;
        done_pulse = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                gclk_nxt = 1'b0;
                if (run_set) state_nxt = RUN;
            end
            RUN: begin
                if (run_clr) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    gclk_nxt  = 1'b0;
                end else if (restart || (run_set && expire)) begin
                    cnt_nxt  = '0;
                    gclk_nxt = 1'b0;
                end else if (expire) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    gclk_nxt   = 1'b0;
                    done_pulse = 1'b1;
                end else if (tick) begin
                    cnt_nxt  = '0;
                    gclk_nxt = ~gclk;
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/gpio_clkgen.sv
// Avalon-MM output port with per-bit static/clock mode and a shared clock generator.
// Define GPIO_CLKGEN_BURST_EN to build the BURST register and sticky DONE flag.
module gpio_clkgen
    import gpio_clkgen_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    gpio_clkgen_if.slave     bus,
    output logic [WIDTH-1:0] out_port
);
`ifdef GPIO_CLKGEN_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic [31:0]        wd, rdata;
    logic               wr, wr_ctrl;
    logic [WIDTH-1:0]   data_q, mode_q;
    logic [DIV_W-1:0]   div_q;
    logic               run_q;
    logic [BURST_W-1:0] burst_q;
    logic               done_q;
    logic               gclk, running, done_pulse, restart;
    logic               unused_wd;

    assign wd        = bus.writedata;
    assign unused_wd = ^wd;
    assign wr        = bus.chipselect && !bus.write_n;
    assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);

    // Any reprogramming of the timebase resynchronises the generator.
    assign restart = wr && ((bus.address == ADDR_CTRL && wd[CTRL_RESTART]) ||
                            bus.address == ADDR_DIVISOR ||
                            (BURST_EN && bus.address == ADDR_BURST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            mode_q   <= '0;
            div_q    <= '0;
            run_q    <= 1'b0;
            out_port <= '0;
        end else begin
            if (wr) begin
                case (bus.address)
                    ADDR_DATA:     data_q <= wd[WIDTH-1:0];
                    ADDR_MODE:     mode_q <= wd[WIDTH-1:0];
                    ADDR_DIVISOR:  div_q  <= wd[DIV_W-1:0];
                    ADDR_OUTSET:   data_q <= data_q | wd[WIDTH-1:0];
                    ADDR_OUTCLEAR: data_q <= data_q & ~wd[WIDTH-1:0];
                    default: ;
                endcase
            end
            if (wr_ctrl)         run_q <= wd[CTRL_RUN];
            else if (done_pulse) run_q <= 1'b0;
            out_port <= data_q ^ (mode_q & {WIDTH{gclk}});
        end
    end

`ifdef GPIO_CLKGEN_BURST_EN
    // DONE set takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            if (wr && bus.address == ADDR_BURST) burst_q <= wd[BURST_W-1:0];
            if (done_pulse)
                done_q <= 1'b1;
            else if (wr && bus.address == ADDR_STATUS && wd[STAT_DONE])
                done_q <= 1'b0;
        end
    end
`else
    assign burst_q = '0;
    assign done_q  = 1'b0;
`endif

    gpio_clkgen_divider #(.DIV_W(DIV_W)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_set    (wr_ctrl && wd[CTRL_RUN]),
        .run_clr    (wr_ctrl && !wd[CTRL_RUN]),
        .restart    (restart),
        .divisor    (div_q),
        .burst      (burst_q),
        .gclk       (gclk),
        .running    (running),
        .done_pulse (done_pulse)
    );

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:    rdata = 32'(data_q);
            ADDR_MODE:    rdata = 32'(mode_q);
            ADDR_DIVISOR: rdata = 32'(div_q);
            ADDR_CTRL:    rdata[CTRL_RUN] = run_q;
            ADDR_BURST:   rdata = 32'(burst_q);
            ADDR_STATUS: begin
                rdata[STAT_RUNNING] = running;
                rdata[STAT_DONE]    = done_q;
            end
            default: rdata = '0;
        endcase
    end
    assign bus.readdata = rdata;
endmodule

// File: tb/tb_gpio_clkgen.sv
// Directed bench for gpio_clkgen: register table, generated waveforms, burst and reset.
module tb_gpio_clkgen;
    import gpio_clkgen_pkg::*;

    localparam int W  = 4;
    localparam int DW = 16;
`ifdef GPIO_CLKGEN_BURST_EN
    localparam logic [31:0] BURST_RB = 32'h5;
`else
    localparam logic [31:0] BURST_RB = 32'h0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] out_port;
    int           nerr = 0;
    int           nchk = 0;

    gpio_clkgen_if bus();

    gpio_clkgen #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
        logic [2:0]  ra;
        logic [31:0] rexp;
        logic [3:0]  pexp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rdchk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        chk(nm, bus.readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev;
        int         rises;
        logic       lastp;

        bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;

        vecs[0]  = '{ADDR_DATA,     32'h5,         ADDR_DATA,     32'h5,    4'h5};
        vecs[1]  = '{ADDR_OUTSET,   32'h2,         ADDR_DATA,     32'h7,    4'h7};
        vecs[2]  = '{ADDR_OUTCLEAR, 32'h4,         ADDR_DATA,     32'h3,    4'h3};
        vecs[3]  = '{ADDR_OUTSET,   32'h0,         ADDR_OUTSET,   32'h0,    4'h3};
        vecs[4]  = '{ADDR_OUTCLEAR, 32'h0,         ADDR_OUTCLEAR, 32'h0,    4'h3};
        vecs[5]  = '{ADDR_DIVISOR,  32'h12345,     ADDR_DIVISOR,  32'h2345, 4'h3};
        vecs[6]  = '{ADDR_MODE,     32'hA,         ADDR_MODE,     32'hA,    4'h3};
        vecs[7]  = '{ADDR_CTRL,     32'h2,         ADDR_CTRL,     32'h0,    4'h3};
        vecs[8]  = '{ADDR_DATA,     32'hFFFF_FFFF, ADDR_DATA,     32'hF,    4'hF};
        vecs[9]  = '{ADDR_MODE,     32'h0,         ADDR_MODE,     32'h0,    4'hF};
        vecs[10] = '{ADDR_BURST,    32'h5,         ADDR_BURST,    BURST_RB, 4'hF};
        vecs[11] = '{ADDR_BURST,    32'h0,         ADDR_BURST,    32'h0,    4'hF};
        vecs[12] = '{ADDR_OUTCLEAR, 32'hFFFF_FFFF, ADDR_DATA,     32'h0,    4'h0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("out_in_reset", 32'(out_port), 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rdchk($sformatf("reset_rd%0d", a), 3'(a), 32'h0);
        chk("out_after_reset", 32'(out_port), 32'h0);

        // Register table with one-cycle pin latency
        prev = 4'h0;
        for (int i = 0; i < 13; i++) begin
            wr(vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_pin_hold", i), 32'(out_port), 32'(prev));
            @(negedge clk);
            chk($sformatf("vec%0d_pin", i), 32'(out_port), 32'(vecs[i].pexp));
            rdchk($sformatf("vec%0d_rd", i), vecs[i].ra, vecs[i].rexp);
            prev = vecs[i].pexp;
        end

        // DIVISOR=3: period 8, first pin rise 5 cycles after the RUN write
        wr(ADDR_MODE, 32'h1);
        wr(ADDR_DIVISOR, 32'h3);
        wr(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("div3_k%0d", k), 32'(out_port[0]), 32'(((k - 1) / 4) % 2));
        end
        rdchk("div3_status", ADDR_STATUS, 32'h1);
        wr(ADDR_CTRL, 32'h0);

        // Inverted polarity, then stop while gclk is high
        wr(ADDR_DATA, 32'h1);
        wr(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("inv_k%0d", k), 32'(out_port[0]), 32'(1 ^ (((k - 1) / 4) % 2)));
        end
        wr(ADDR_CTRL, 32'h0);
        chk("stop_pin_edge", 32'(out_port[0]), 32'h0);
        @(negedge clk);
        chk("stop_pin_data", 32'(out_port[0]), 32'h1);
        rdchk("stop_status", ADDR_STATUS, 32'h0);

        // Mid-run divisor change 1 -> 5 while gclk is high
        wr(ADDR_DATA, 32'h0);
        wr(ADDR_DIVISOR, 32'h1);
        wr(ADDR_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        wr(ADDR_DIVISOR, 32'h5);
        chk("div5_pre_drop", 32'(out_port[0]), 32'h1);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk($sformatf("div5_k%0d", k), 32'(out_port[0]), 32'(((k - 1) / 6) % 2));
        end
        rdchk("div5_rd", ADDR_DIVISOR, 32'h5);
        wr(ADDR_CTRL, 32'h0);
        @(negedge clk);

`ifdef GPIO_CLKGEN_BURST_EN
        // Three-pulse burst at DIVISOR=0
        wr(ADDR_DIVISOR, 32'h0);
        wr(ADDR_BURST, 32'h3);
        wr(ADDR_CTRL, 32'h1);
        rises = 0;
        lastp = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("burst_k%0d", k), 32'(out_port[0]),
                32'((k >= 2 && k <= 6) ? ((k % 2) == 0) : 0));
            if (out_port[0] && !lastp) rises++;
            lastp = out_port[0];
        end
        chk("burst_pulses", 32'(rises), 32'd3);
        rdchk("burst_ctrl", ADDR_CTRL, 32'h0);
        rdchk("burst_status", ADDR_STATUS, 32'h2);
        wr(ADDR_STATUS, 32'h2);
        rdchk("done_w1c", ADDR_STATUS, 32'h0);

        // RUN rewrite in the expiry cycle restarts instead of finishing
        wr(ADDR_BURST, 32'h2);
        wr(ADDR_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        wr(ADDR_CTRL, 32'h1);
        rdchk("expiry_rewrite", ADDR_STATUS, 32'h1);
        repeat (3) @(negedge clk);
        rdchk("rerun_busy", ADDR_STATUS, 32'h1);
        repeat (2) @(negedge clk);
        rdchk("rerun_done", ADDR_STATUS, 32'h2);
        wr(ADDR_STATUS, 32'h2);
        rdchk("rerun_w1c", ADDR_STATUS, 32'h0);
`else
        // Without burst support address 6 is inert and the generator free-runs
        wr(ADDR_BURST, 32'h3);
        rdchk("noburst_rd", ADDR_BURST, 32'h0);
        wr(ADDR_DIVISOR, 32'h0);
        wr(ADDR_CTRL, 32'h1);
        rises = 0;
        lastp = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_port[0] && !lastp) rises++;
            lastp = out_port[0];
        end
        chk("freerun_pulses", 32'(rises), 32'd6);
        rdchk("freerun_status", ADDR_STATUS, 32'h1);
        wr(ADDR_CTRL, 32'h0);
`endif

        // Asynchronous reset in the middle of a burst
        wr(ADDR_BURST, 32'd100);
        wr(ADDR_DIVISOR, 32'h0);
        wr(ADDR_DATA, 32'hE);
        wr(ADDR_MODE, 32'h1);
        wr(ADDR_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        chk("pre_reset_pins", 32'(out_port[3:1]), 32'h7);
        reset_n = 1'b0;
        #1;
        chk("async_reset_pins", 32'(out_port), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        rdchk("post_reset_status", ADDR_STATUS, 32'h0);
        rdchk("post_reset_data", ADDR_DATA, 32'h0);
        chk("post_reset_pins", 32'(out_port), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
